// File: rtl/uart_rcv_param.sv
// uart_rcv_param: parametrised UART receiver (DATA_W/BAUD_DIV/STOP_BITS).
// Optional parity state and par_err port when UART_RCV_PARITY_EN is defined.
module uart_rcv_param #(
    parameter int DATA_W    = 8,
    parameter int BAUD_DIV  = 2604,
    parameter int STOP_BITS = 1
`ifdef UART_RCV_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX,
    input  logic              rx_rdy_clr,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_rdy,
    output logic              frm_err,
    output logic              ovr_err,
`ifdef UART_RCV_PARITY_EN
    output logic              par_err,
`endif
    output logic              busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] LAST_B  = BW'(DATA_W - 1);
    localparam logic          LAST_S  = 1'(STOP_BITS - 1);

`ifdef UART_RCV_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BRK
    } state_t;
`endif

    state_t            state, state_n;
    logic              rx_m, rx_s;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic              stop_idx;
    logic              bad;
    logic [DATA_W-1:0] sh;
    logic              cnt_clr, go, smp_data, smp_stop, done;
    logic              bad_now;
`ifdef UART_RCV_PARITY_EN
    logic              par_bit, smp_par, par_bad;
`endif

    assign busy    = (state != S_IDLE);
    assign bad_now = bad | ~rx_s;
`ifdef UART_RCV_PARITY_EN
    assign par_bad = (^sh) ^ par_bit ^ PARITY_ODD;
`endif

    // two-flop synchroniser for the asynchronous RX pad
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // next state and per-cycle sample strobes
    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        go       = 1'b0;
        smp_data = 1'b0;
        smp_stop = 1'b0;
        done     = 1'b0;
`ifdef UART_RCV_PARITY_EN
        smp_par  = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt == HALF_M1) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end else begin
                        go      = 1'b1;
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_clr  = 1'b1;
                    smp_data = 1'b1;
                    if (bit_idx == LAST_B) begin
`ifdef UART_RCV_PARITY_EN
                        state_n = S_PAR;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RCV_PARITY_EN
            S_PAR: begin
                if (cnt == FULL_M1) begin
                    cnt_clr = 1'b1;
                    smp_par = 1'b1;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_clr  = 1'b1;
                    smp_stop = 1'b1;
                    if (stop_idx == LAST_S) begin
                        done    = 1'b1;
                        state_n = rx_s ? S_IDLE : S_BRK;
                    end
                end
            end
            S_BRK: begin
                cnt_clr = 1'b1;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                cnt_clr = 1'b1;
                state_n = S_IDLE;
            end
        endcase
    end

    // baud counter, bit counters, shift register and stop-bit health
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            bad      <= 1'b0;
            sh       <= '0;
`ifdef UART_RCV_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            cnt <= cnt_clr ? '0 : cnt + 1'b1;
            if (go) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                bad      <= 1'b0;
            end
            if (smp_data) begin
                sh      <= {rx_s, sh[DATA_W-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
`ifdef UART_RCV_PARITY_EN
            if (smp_par) par_bit <= rx_s;
`endif
            if (smp_stop) begin
                stop_idx <= stop_idx + 1'b1;
                bad      <= bad_now;
            end
        end
    end

    // hand-off word and sticky flags; a new frame wins over the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data <= '0;
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
`ifdef UART_RCV_PARITY_EN
            par_err <= 1'b0;
`endif
        end else if (done) begin
            rx_data <= sh;
            rx_rdy  <= 1'b1;
            frm_err <= bad_now | (frm_err & ~rx_rdy_clr);
            ovr_err <= (rx_rdy | ovr_err) & ~rx_rdy_clr;
`ifdef UART_RCV_PARITY_EN
            par_err <= par_bad | (par_err & ~rx_rdy_clr);
`endif
        end else if (rx_rdy_clr) begin
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
`ifdef UART_RCV_PARITY_EN
            par_err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rcv_param.sv
// tb_uart_rcv_param: scoreboard bench for uart_rcv_param.
// Parity DUT is exercised only when UART_RCV_PARITY_EN is defined.
module tb_uart_rcv_param;

    localparam int BAUD = 16;
    localparam int HALF = BAUD / 2;
`ifdef UART_RCV_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int DONE_E = 3 + HALF + BAUD * (8 + PB + 1);

    typedef struct packed {
        logic [7:0] d;
        logic       frm;
        logic       ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       rx_rdy_clr;
    logic [7:0] rx_data;
    logic       rx_rdy, frm_err, ovr_err, busy;
`ifdef UART_RCV_PARITY_EN
    logic       par_err;
    logic       RX2, clr2;
    logic [6:0] p_data;
    logic       p_rdy, p_frm, p_ovr, p_busy, p_par;
`endif

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_rcv_param #(
        .DATA_W(8), .BAUD_DIV(BAUD), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .RX(RX), .rx_rdy_clr(rx_rdy_clr),
        .rx_data(rx_data), .rx_rdy(rx_rdy),
        .frm_err(frm_err), .ovr_err(ovr_err),
`ifdef UART_RCV_PARITY_EN
        .par_err(par_err),
`endif
        .busy(busy)
    );

`ifdef UART_RCV_PARITY_EN
    uart_rcv_param #(
        .DATA_W(7), .BAUD_DIV(BAUD), .STOP_BITS(2), .PARITY_ODD(1'b0)
    ) pdut (
        .clk(clk), .rst(rst), .RX(RX2), .rx_rdy_clr(clr2),
        .rx_data(p_data), .rx_rdy(p_rdy),
        .frm_err(p_frm), .ovr_err(p_ovr),
        .par_err(p_par), .busy(p_busy)
    );
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp_v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sbit(input logic b);
        RX = b;
        idle(BAUD);
    endtask

    task automatic send8(input logic [7:0] d, input logic stopb);
        sbit(1'b0);
        for (int i = 0; i < 8; i++) sbit(d[i]);
`ifdef UART_RCV_PARITY_EN
        sbit(^d);
`endif
        sbit(stopb);
    endtask

    task automatic pulse_clr();
        rx_rdy_clr = 1'b1;
        idle(1);
        rx_rdy_clr = 1'b0;
        idle(1);
    endtask

`ifdef UART_RCV_PARITY_EN
    task automatic pbit(input logic b);
        RX2 = b;
        idle(BAUD);
    endtask

    task automatic send7(input logic [6:0] d, input logic par);
        pbit(1'b0);
        for (int i = 0; i < 7; i++) pbit(d[i]);
        pbit(par);
        pbit(1'b1);
        pbit(1'b1);
    endtask
`endif

    task automatic monitor();
        logic [10:0] prev;
        logic [10:0] cur;
        exp_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {rx_rdy, frm_err, ovr_err, rx_data};
            if (rx_rdy && cur != prev) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h, required none",
                             rx_data);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_data", {24'b0, rx_data}, {24'b0, e.d});
                    chk("sb_frm", {31'b0, frm_err}, {31'b0, e.frm});
                    chk("sb_ovr", {31'b0, ovr_err}, {31'b0, e.ovr});
                end
            end
            prev = cur;
        end
    endtask

    initial begin
        rst        = 1'b1;
        RX         = 1'b1;
        rx_rdy_clr = 1'b0;
`ifdef UART_RCV_PARITY_EN
        RX2  = 1'b1;
        clr2 = 1'b0;
`endif
        fork
            monitor();
        join_none
        idle(3);
        chk("rst_data", {24'b0, rx_data}, 32'h0);
        chk("rst_rdy", {31'b0, rx_rdy}, 32'h0);
        chk("rst_frm", {31'b0, frm_err}, 32'h0);
        chk("rst_ovr", {31'b0, ovr_err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        idle(5);

        sbq.push_back('{8'hA5, 1'b0, 1'b0});
        send8(8'hA5, 1'b1);
        idle(4);
        chk("a5_busy", {31'b0, busy}, 32'h0);
        chk("a5_rdy", {31'b0, rx_rdy}, 32'h1);
        pulse_clr();
        chk("a5_clr", {31'b0, rx_rdy}, 32'h0);

        RX = 1'b0;
        idle(4);
        RX = 1'b1;
        idle(2);
        chk("glitch_busy_hi", {31'b0, busy}, 32'h1);
        idle(8);
        chk("glitch_busy_lo", {31'b0, busy}, 32'h0);
        chk("glitch_rdy", {31'b0, rx_rdy}, 32'h0);
        idle(4);

        sbq.push_back('{8'h3C, 1'b1, 1'b0});
        send8(8'h3C, 1'b0);
        idle(100);
        chk("brk_busy", {31'b0, busy}, 32'h1);
        chk("brk_frm", {31'b0, frm_err}, 32'h1);
        RX = 1'b1;
        idle(4);
        chk("brk_exit", {31'b0, busy}, 32'h0);
        pulse_clr();
        chk("brk_clr", {31'b0, frm_err}, 32'h0);

        sbq.push_back('{8'h11, 1'b0, 1'b0});
        send8(8'h11, 1'b1);
        sbq.push_back('{8'h22, 1'b0, 1'b1});
        send8(8'h22, 1'b1);
        idle(4);
        chk("ovr_data", {24'b0, rx_data}, 32'h22);
        pulse_clr();
        chk("ovr_clr_rdy", {31'b0, rx_rdy}, 32'h0);
        chk("ovr_clr_ovr", {31'b0, ovr_err}, 32'h0);

        sbq.push_back('{8'h7E, 1'b0, 1'b0});
        fork
            send8(8'h7E, 1'b1);
            begin
                repeat (DONE_E - 1) @(posedge clk);
                #1 rx_rdy_clr = 1'b1;
                @(posedge clk);
                #1 rx_rdy_clr = 1'b0;
            end
        join
        idle(4);
        chk("coin_rdy", {31'b0, rx_rdy}, 32'h1);
        chk("coin_ovr", {31'b0, ovr_err}, 32'h0);

        RX = 1'b0;
        idle(BAUD);
        RX = 1'b1;
        idle(40);
        rst = 1'b1;
        idle(2);
        chk("mid_rst_data", {24'b0, rx_data}, 32'h0);
        chk("mid_rst_rdy", {31'b0, rx_rdy}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        idle(5);
        sbq.push_back('{8'h01, 1'b0, 1'b0});
        send8(8'h01, 1'b1);
        idle(4);
        chk("post_rst_rdy", {31'b0, rx_rdy}, 32'h1);

`ifdef UART_RCV_PARITY_EN
        send7(7'h55, 1'b1);
        idle(4);
        chk("par_data", {25'b0, p_data}, 32'h55);
        chk("par_err_bad", {31'b0, p_par}, 32'h1);
        chk("par_frm", {31'b0, p_frm}, 32'h0);
        clr2 = 1'b1;
        idle(1);
        clr2 = 1'b0;
        idle(1);
        chk("par_clr", {31'b0, p_par}, 32'h0);
        send7(7'h03, 1'b0);
        idle(4);
        chk("par_ok_data", {25'b0, p_data}, 32'h03);
        chk("par_err_ok", {31'b0, p_par}, 32'h0);
`endif

        for (int i = 0; i < 200 && sbq.size() != 0; i++) idle(1);
        chk("sb_empty", sbq.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
